// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing one main_memory_interface among NUM_PORTS caches.
// One request in flight at a time; the response is returned to the winner only.
module main_memory_arbiter #(
  parameter int OFFSET_BITS   = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MSG_BITS      = 4,
  parameter int NUM_PORTS     = 2,
  // Must match the message encoding used by the caches and the interface
  parameter logic [MSG_BITS-1:0] NO_REQ   = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] MEM_RESP = MSG_BITS'(4),
  localparam int BUS_WIDTH = DATA_WIDTH << OFFSET_BITS,
  localparam int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]      cache2arb_msg,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2arb_address,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]     cache2arb_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]      arb2cache_msg,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] arb2cache_address,
  output logic [NUM_PORTS*BUS_WIDTH-1:0]     arb2cache_data,
  output logic [MSG_BITS-1:0]                arb2interface_msg,
  output logic [ADDRESS_WIDTH-1:0]           arb2interface_address,
  output logic [BUS_WIDTH-1:0]               arb2interface_data,
  input  logic [MSG_BITS-1:0]                interface2arb_msg,
  input  logic [ADDRESS_WIDTH-1:0]           interface2arb_address,
  input  logic [BUS_WIDTH-1:0]               interface2arb_data,
  output logic [PORT_BITS-1:0]               grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t                                   state, state_n;
  logic [PORT_BITS-1:0]                     ptr, win, idx;
  logic                                     win_vld, rsp_ok, drop;
  logic [NUM_PORTS-1:0]                     req;
  logic [NUM_PORTS-1:0][MSG_BITS-1:0]       c_msg, o_msg;
  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]  c_addr, o_addr;
  logic [NUM_PORTS-1:0][BUS_WIDTH-1:0]      c_data, o_data;
  logic [ADDRESS_WIDTH-1:0]                 rsp_addr;
  logic [BUS_WIDTH-1:0]                     rsp_data;

  assign c_msg  = cache2arb_msg;
  assign c_addr = cache2arb_address;
  assign c_data = cache2arb_data;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    assign req[i] = (c_msg[i] != NO_REQ);
  end

  // Scan from the highest offset down so the port closest to ptr wins last
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      idx = ptr + PORT_BITS'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign rsp_ok = (interface2arb_msg == MEM_RESP) && (interface2arb_address == arb2interface_address);
  assign drop   = (c_msg[grant] == NO_REQ);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_vld) state_n = BUSY;
      BUSY:    if (rsp_ok)  state_n = RESPOND;
      RESPOND: if (drop)    state_n = IDLE;
      default:              state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr                   <= '0;
      grant                 <= '0;
      arb2interface_msg     <= NO_REQ;
      arb2interface_address <= '0;
      arb2interface_data    <= '0;
      rsp_addr              <= '0;
      rsp_data              <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          grant                 <= win;
          arb2interface_msg     <= c_msg[win];
          arb2interface_address <= c_addr[win];
          arb2interface_data    <= c_data[win];
        end
        BUSY: if (rsp_ok) begin
          rsp_addr          <= interface2arb_address;
          rsp_data          <= interface2arb_data;
          arb2interface_msg <= NO_REQ;
        end
        RESPOND: if (drop) ptr <= grant + PORT_BITS'(1);
        default: ;
      endcase
    end
  end

  // Response fan-out depends only on registered state, so it is glitch-free
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_msg[i]  = NO_REQ;
      o_addr[i] = '0;
      o_data[i] = '0;
      if (state == RESPOND && grant == PORT_BITS'(i)) begin
        o_msg[i]  = MEM_RESP;
        o_addr[i] = rsp_addr;
        o_data[i] = rsp_data;
      end
    end
  end

  assign arb2cache_msg     = o_msg;
  assign arb2cache_address = o_addr;
  assign arb2cache_data    = o_data;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Randomized bench for main_memory_arbiter (4 ports) against a transaction-level
// round-robin model: pending set + rotating pointer, served one at a time.
module tb_main_memory_arbiter;
  localparam int N = 4, MW = 4, AW = 12, BW = 32, PB = 2;
  localparam logic [MW-1:0] NO_REQ = 4'd0, R_REQ = 4'd1, WB_REQ = 4'd2, FLUSH = 4'd3, MEM_RESP = 4'd4;

  logic clock = 1'b0, reset = 1'b0;
  logic [N*MW-1:0] cache2arb_msg, arb2cache_msg;
  logic [N*AW-1:0] cache2arb_address, arb2cache_address;
  logic [N*BW-1:0] cache2arb_data, arb2cache_data;
  logic [MW-1:0] arb2interface_msg, i_msg = NO_REQ;
  logic [AW-1:0] arb2interface_address, i_addr = '0;
  logic [BW-1:0] arb2interface_data, i_data = '0;
  logic [PB-1:0] grant;

  logic [MW-1:0] c_msg [N];
  logic [AW-1:0] c_addr[N];
  logic [BW-1:0] c_data[N];

  always_comb begin
    cache2arb_msg = '0; cache2arb_address = '0; cache2arb_data = '0;
    for (int p = 0; p < N; p++) begin
      cache2arb_msg[p*MW +: MW]     = c_msg[p];
      cache2arb_address[p*AW +: AW] = c_addr[p];
      cache2arb_data[p*BW +: BW]    = c_data[p];
    end
  end

  main_memory_arbiter #(.NUM_PORTS(N)) dut (
    .clock(clock), .reset(reset),
    .cache2arb_msg(cache2arb_msg), .cache2arb_address(cache2arb_address), .cache2arb_data(cache2arb_data),
    .arb2cache_msg(arb2cache_msg), .arb2cache_address(arb2cache_address), .arb2cache_data(arb2cache_data),
    .arb2interface_msg(arb2interface_msg), .arb2interface_address(arb2interface_address),
    .arb2interface_data(arb2interface_data),
    .interface2arb_msg(i_msg), .interface2arb_address(i_addr), .interface2arb_data(i_data),
    .grant(grant)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  int mptr = 0;
  bit pend[N];
  logic [MW-1:0] rq_msg [N];
  logic [AW-1:0] rq_addr[N];
  logic [BW-1:0] rq_data[N];
  int gseq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] cmsg(input int p);  return arb2cache_msg[p*MW +: MW];     endfunction
  function automatic logic [AW-1:0] caddr(input int p); return arb2cache_address[p*AW +: AW]; endfunction
  function automatic logic [BW-1:0] cdata(input int p); return arb2cache_data[p*BW +: BW];    endfunction

  task automatic tick(); @(posedge clock); #1; endtask

  task automatic post(input int p, input logic [MW-1:0] m, input logic [AW-1:0] a, input logic [BW-1:0] d);
    c_msg[p] = m; c_addr[p] = a; c_data[p] = d;
    rq_msg[p] = m; rq_addr[p] = a; rq_data[p] = d; pend[p] = 1'b1;
  endtask

  task automatic post_rand(input int p);
    post(p, MW'($urandom_range(1, 3)), AW'($urandom), $urandom);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < N; p++) begin c_msg[p] = NO_REQ; c_addr[p] = '0; c_data[p] = '0; pend[p] = 1'b0; end
    i_msg = NO_REQ; i_addr = '0; i_data = '0;
  endtask

  task automatic check_quiet(input string tag);
    for (int p = 0; p < N; p++) begin
      chk({tag, "_cmsg"}, cmsg(p), NO_REQ);
      chk({tag, "_caddr"}, caddr(p), 0);
      chk({tag, "_cdata"}, cdata(p), 0);
    end
    chk({tag, "_imsg"}, arb2interface_msg, NO_REQ);
  endtask

  // One full transaction: grant edge, optional input tampering / extra request /
  // wrong-address response, matching response, hold, cache drop.
  task automatic serve(input bit mismatch, input bit tamper, input int extra, input logic [BW-1:0] rdata);
    int w;
    w = pick();
    tick();
    chk("grant", grant, w);
    chk("req_msg", arb2interface_msg, rq_msg[w]);
    chk("req_addr", arb2interface_address, rq_addr[w]);
    chk("req_data", arb2interface_data, rq_data[w]);
    gseq.push_back(w);
    if (extra >= 0 && !pend[extra]) post_rand(extra);
    if (tamper) begin
      c_addr[w] = 12'h3FF; c_data[w] = $urandom;
      tick();
      chk("hold_addr", arb2interface_address, rq_addr[w]);
      chk("hold_data", arb2interface_data, rq_data[w]);
    end
    if (mismatch) begin
      i_msg = MEM_RESP; i_addr = rq_addr[w] ^ 12'h004; i_data = $urandom;
      tick();
      chk("mismatch_ignored", cmsg(w), NO_REQ);
      chk("mismatch_busy", arb2interface_msg, rq_msg[w]);
    end
    i_msg = MEM_RESP; i_addr = rq_addr[w]; i_data = rdata;
    tick();
    i_msg = NO_REQ; i_addr = '0; i_data = '0;
    for (int p = 0; p < N; p++) begin
      chk("rsp_msg", cmsg(p), (p == w) ? MEM_RESP : NO_REQ);
      chk("rsp_addr", caddr(p), (p == w) ? rq_addr[w] : '0);
      chk("rsp_data", cdata(p), (p == w) ? rdata : '0);
    end
    chk("if_idle_msg", arb2interface_msg, NO_REQ);
    chk("if_hold_addr", arb2interface_address, rq_addr[w]);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("rsp_held", cmsg(w), MEM_RESP);
    end
    c_msg[w] = NO_REQ; pend[w] = 1'b0;
    tick();
    chk("rsp_drop", cmsg(w), NO_REQ);
    mptr = (w + 1) % N;
  endtask

  task automatic do_reset();
    reset = 1'b0; clear_inputs(); mptr = 0;
    tick(); tick();
    check_quiet("reset");
    chk("reset_grant", grant, 0);
    chk("reset_iaddr", arb2interface_address, 0);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int start, ex;
    clear_inputs();
    do_reset();

    // simultaneous requests straight after reset: port0 then port1
    start = gseq.size();
    post(0, R_REQ, 12'h100, $urandom);
    post(1, WB_REQ, 12'h200, 32'h99887766);
    serve(0, 0, -1, $urandom);
    serve(0, 0, -1, $urandom);
    chk("simul_seq0", gseq[start], 0);
    chk("simul_seq1", gseq[start+1], 1);

    // single read; pointer afterwards must favour port1 over port0
    post(0, R_REQ, 12'h104, '0);
    serve(0, 0, -1, 32'h44332211);
    post(0, R_REQ, 12'h040, $urandom);
    post(1, R_REQ, 12'h050, $urandom);
    start = gseq.size();
    serve(0, 0, -1, $urandom);
    serve(0, 0, -1, $urandom);
    chk("ptr_after_single", gseq[start], 1);

    // wrong-address response ignored, then delivered
    post(1, FLUSH, 12'h324, 32'h12345678);
    serve(1, 0, -1, $urandom);
    // cache inputs changing while busy
    post(0, R_REQ, 12'h104, $urandom);
    serve(0, 1, -1, $urandom);

    // fairness with every port continuously re-requesting
    do_reset();
    start = gseq.size();
    for (int p = 0; p < N; p++) post_rand(p);
    for (int t = 0; t < 5; t++) begin
      serve(0, 0, -1, $urandom);
      post_rand(gseq[$]);
    end
    for (int t = 0; t < 5; t++) chk("fair_seq", gseq[start+t], t % N);
    while (pick() >= 0) serve(0, 0, -1, $urandom);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < N; p++) if (!pend[p] && $urandom_range(0, 3) == 0) post_rand(p);
      if (pick() >= 0) begin
        ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N-1)) : -1;
        serve($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ex, $urandom);
      end else begin
        tick();
        chk("idle_quiet", arb2interface_msg, NO_REQ);
      end
    end
    while (pick() >= 0) serve(0, 0, -1, $urandom);

    // asynchronous reset while busy on port1
    post(1, R_REQ, 12'h2A0, $urandom);
    tick();
    chk("pre_reset_grant", grant, 1);
    chk("pre_reset_busy", arb2interface_msg, R_REQ);
    #2 reset = 1'b0;
    #1;
    check_quiet("async_reset");
    chk("async_reset_grant", grant, 0);
    clear_inputs(); mptr = 0;
    tick();
    reset = 1'b1;
    tick();
    post(1, WB_REQ, 12'h1F0, $urandom);
    serve(0, 0, -1, $urandom);
    chk("post_reset_grant", gseq[$], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
